mem_ctrl: RTL and testbench
===========================

MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameters: none; RAM read latency is fixed at 1 cycle.
REQ-002 clk_in  input  1  the single clock; all state changes on its rising edge.
REQ-003 rst_in  input  1  asynchronous, active-low reset.
REQ-004 if_req  input  1  IF stage requests a 4-byte instruction fetch; held high until if_done is seen.
REQ-005 if_addr  input  32  fetch address.
REQ-006 flush_in  input  1  jump redirect; abandons any IF fetch.
REQ-007 mem_req  input  1  MEM stage requests a load/store; held high until mem_done is seen.
REQ-008 mem_we  input  1  1 = store, 0 = load.
REQ-009 mem_addr  input  32  data address.
REQ-010 mem_len  input  2  0 = byte, 1 = half, 2 or 3 = word.
REQ-011 mem_wdata  input  32  store data, little-endian, low bytes used.
REQ-012 ram_din  input  8  RAM read byte, valid 1 cycle after its address.
REQ-013 ram_addr  output  32  RAM byte address.
REQ-014 ram_we  output  1  RAM write strobe.
REQ-015 ram_dout  output  8  RAM write byte.
REQ-016 if_done  output  1  one-cycle pulse; if_data is valid.
REQ-017 if_data  output  32  fetched instruction.
REQ-018 mem_done  output  1  one-cycle pulse; the load or store is complete.
REQ-019 mem_rdata  output  32  load data, zero-extended to 32 bits.

Function
REQ-020 The FSM SHALL have the states IDLE, IF_RD, MEM_RD, MEM_WR and DONE.
REQ-021 In IDLE, mem_req SHALL win over if_req. Transitions on a grant:
- mem_req with mem_we=1 -> MEM_WR
- mem_req with mem_we=0 -> MEM_RD
- otherwise if_req and !flush_in -> IF_RD
REQ-022 On grant, the address, length, we and wdata SHALL be latched; requester inputs SHALL be ignored until the FSM returns to IDLE.
REQ-023 Byte count n SHALL be 1, 2 or 4 from the latched length; IF fetches SHALL always use n=4.
REQ-024 Read states SHALL use a byte counter c = 0..n:
- for c<n, drive ram_addr = base+c (32-bit wrap-around);
- for c>=1, capture ram_din into byte c-1 of the result;
- after c=n, go to DONE.
REQ-025 MEM_WR SHALL use c = 0..n-1, driving ram_we=1, ram_addr=base+c and ram_dout = wdata byte c; after c=n-1, go to DONE.
REQ-026 DONE SHALL last exactly one cycle:
- pulse if_done or mem_done, matching the granted requester;
- then return to IDLE;
- no grant is made in DONE.
REQ-027 Latency SHALL be counted from the IDLE cycle in which the request is granted (cycle 0) to the cycle of the done pulse:
- reads: done in cycle n+2 (word fetch = cycle 6);
- writes: done in cycle n+1.
REQ-028 if_data and mem_rdata SHALL update only when their done pulse is issued and hold their value until the next done pulse of the same kind.
REQ-029 Outside MEM_WR, ram_we SHALL be 0 and ram_dout SHALL be 0. ram_addr SHALL be 0 in IDLE and DONE.
REQ-030 flush_in during IF_RD SHALL abort the fetch:
- go to IDLE on the next edge;
- no if_done and no if_data update;
- bytes already read are discarded.
REQ-031 flush_in during MEM_RD, MEM_WR or DONE SHALL have no effect.
REQ-032 A load SHALL fill the upper bytes beyond n with 0; sign extension is the MEM stage's responsibility.

Reset
REQ-033 While rst_in=0, asynchronously:
- state = IDLE, c = 0;
- ram_addr, ram_we, ram_dout = 0;
- if_done, mem_done = 0;
- if_data, mem_rdata = 0x00000000.
REQ-034 Reset asserted mid-transaction SHALL abandon it with no done pulse; a write cut off part-way leaves the RAM partially written, which is accepted behaviour.
REQ-035 After rst_in rises, the first grant SHALL occur no earlier than the first rising edge.

Verification
REQ-036 Fetch: if_req=1, if_addr=0x100, RAM[0x100..0x103]=13,05,A0,00 -> ram_addr 0x100..0x103 in cycles 1-4; if_done=1 in cycle 6 with if_data=0x00A00513.
REQ-037 Contention: if_req and mem_req (load, len=0, addr 0x2000, RAM=0xFF) raised in the same cycle -> mem_done first with mem_rdata=0x000000FF; the IF fetch is then granted from IDLE.
REQ-038 Store half: mem_we=1, len=1, addr 0x3000, wdata=0xDEADBEEF -> ram_we=1 for 2 cycles writing EF@0x3000 then BE@0x3001; mem_done in cycle 3.
REQ-039 Flush: flush_in=1 in the 3rd IF_RD cycle -> no if_done, if_data unchanged, FSM in IDLE on the next cycle; a new if_req at 0x200 then completes normally.
REQ-040 Wrap and reset: word load at 0xFFFFFFFE -> addresses FFFFFFFE, FFFFFFFF, 00000000, 00000001. A separate run with rst_in=0 pulsed during MEM_WR -> all outputs 0 immediately and no mem_done.

Source files
------------

// File: rtl/mem_ctrl_if.sv
// Bundle of the IF/MEM request handshakes and the byte-wide RAM port.
//   slave  : the controller side (mem_ctrl) - takes requests and ram_din,
//            drives the RAM strobes, done pulses and read data.
//   master : the pipeline/RAM side - drives requests and ram_din.
interface mem_ctrl_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        flush_in;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [1:0]  mem_len;
    logic [31:0] mem_wdata;
    logic [7:0]  ram_din;
    logic [31:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_dout;
    logic        if_done;
    logic [31:0] if_data;
    logic        mem_done;
    logic [31:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, flush_in, mem_req, mem_we, mem_addr, mem_len, mem_wdata,
               ram_din,
        output ram_addr, ram_we, ram_dout, if_done, if_data, mem_done, mem_rdata
    );

    modport master (
        output if_req, if_addr, flush_in, mem_req, mem_we, mem_addr, mem_len, mem_wdata,
               ram_din,
        input  ram_addr, ram_we, ram_dout, if_done, if_data, mem_done, mem_rdata
    );
endinterface

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller arbitrating an instruction-fetch port and a
// load/store port onto a single 8-bit RAM with 1-cycle read latency.
// Ports:
//   clk_in  - clock, all state changes on the rising edge
//   rst_in  - asynchronous active-low reset
//   bus     - mem_ctrl_if.slave: IF/MEM requests, done pulses, read data and
//             the RAM address/strobe/data lines
// The MEM port has priority. Reads take n+2 cycles from grant to done,
// writes n+1, where n is 1, 2 or 4 bytes.
module mem_ctrl (
    input  logic     clk_in,
    input  logic     rst_in,
    mem_ctrl_if.slave bus
);

    typedef enum logic [2:0] {StIdle, StIfRd, StMemRd, StMemWr, StDone} state_e;

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [2:0]  n_q, n_d;
    logic [31:0] base_q, base_d;
    logic [31:0] wdata_q, wdata_d;
    logic        is_mem_q, is_mem_d;
    logic [31:0] buf_q, buf_d;
    logic [31:0] if_data_q, if_data_d;
    logic [31:0] mem_rdata_q, mem_rdata_d;

    logic [31:0] ram_addr_c;
    logic        ram_we_c;
    logic [7:0]  ram_dout_c;
    logic        if_done_c;
    logic        mem_done_c;
    logic [1:0]  byte_idx;

    // Byte slot filled by the ram_din arriving this cycle (address issued at cnt-1).
    assign byte_idx = cnt_q[1:0] - 2'd1;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        n_d         = n_q;
        base_d      = base_q;
        wdata_d     = wdata_q;
        is_mem_d    = is_mem_q;
        buf_d       = buf_q;
        if_data_d   = if_data_q;
        mem_rdata_d = mem_rdata_q;
        ram_addr_c  = 32'd0;
        ram_we_c    = 1'b0;
        ram_dout_c  = 8'd0;
        if_done_c   = 1'b0;
        mem_done_c  = 1'b0;

        unique case (state_q)
            StIdle: begin
                cnt_d = 3'd0;
                if (bus.mem_req) begin
                    base_d   = bus.mem_addr;
                    wdata_d  = bus.mem_wdata;
                    is_mem_d = 1'b1;
                    buf_d    = 32'd0;
                    unique case (bus.mem_len)
                        2'd0:    n_d = 3'd1;
                        2'd1:    n_d = 3'd2;
                        default: n_d = 3'd4;
                    endcase
                    state_d = bus.mem_we ? StMemWr : StMemRd;
                end else if (bus.if_req && !bus.flush_in) begin
                    base_d   = bus.if_addr;
                    is_mem_d = 1'b0;
                    buf_d    = 32'd0;
                    n_d      = 3'd4;
                    state_d  = StIfRd;
                end
            end

            StIfRd, StMemRd: begin
                if (state_q == StIfRd && bus.flush_in) begin
                    state_d = StIdle;
                    cnt_d   = 3'd0;
                end else begin
                    if (cnt_q < n_q) begin
                        ram_addr_c = base_q + {29'd0, cnt_q};
                    end
                    if (cnt_q != 3'd0) begin
                        buf_d[{byte_idx, 3'b000} +: 8] = bus.ram_din;
                    end
                    if (cnt_q == n_q) begin
                        // Result registers load on entry to DONE so data is valid with the pulse.
                        state_d = StDone;
                        cnt_d   = 3'd0;
                        if (is_mem_q) begin
                            mem_rdata_d = buf_d;
                        end else begin
                            if_data_d = buf_d;
                        end
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end

            StMemWr: begin
                ram_we_c   = 1'b1;
                ram_addr_c = base_q + {29'd0, cnt_q};
                ram_dout_c = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
                if (cnt_q == n_q - 3'd1) begin
                    state_d = StDone;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end

            StDone: begin
                if_done_c  = !is_mem_q;
                mem_done_c = is_mem_q;
                state_d    = StIdle;
            end

            default: begin
                state_d = StIdle;
                cnt_d   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q     <= StIdle;
            cnt_q       <= 3'd0;
            n_q         <= 3'd0;
            base_q      <= 32'd0;
            wdata_q     <= 32'd0;
            is_mem_q    <= 1'b0;
            buf_q       <= 32'd0;
            if_data_q   <= 32'd0;
            mem_rdata_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            n_q         <= n_d;
            base_q      <= base_d;
            wdata_q     <= wdata_d;
            is_mem_q    <= is_mem_d;
            buf_q       <= buf_d;
            if_data_q   <= if_data_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    // RAM strobes and done pulses decode straight from the registered state,
    // so reset forces them to zero immediately.
    assign bus.ram_addr  = ram_addr_c;
    assign bus.ram_we    = ram_we_c;
    assign bus.ram_dout  = ram_dout_c;
    assign bus.if_done   = if_done_c;
    assign bus.mem_done  = mem_done_c;
    assign bus.if_data   = if_data_q;
    assign bus.mem_rdata = mem_rdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed scenarios plus randomized
// fetch/load/store traffic checked against a transaction-level memory model.
module tb_mem_ctrl;

    logic clk_in = 1'b0;
    logic rst_in = 1'b0;

    mem_ctrl_if bus ();

    mem_ctrl dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_errors = 0;

    // Physical RAM (16-bit aliased) and the reference byte memory.
    bit   [7:0] ram    [65536];
    bit         ram_wr [65536];
    logic [7:0] ref_mem [int unsigned];

    logic [31:0] exp_if_data;
    logic [31:0] exp_mem_rdata;

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        logic [7:0] v;
        case (a)
            32'h0000_0100: v = 8'h13;
            32'h0000_0101: v = 8'h05;
            32'h0000_0102: v = 8'hA0;
            32'h0000_0103: v = 8'h00;
            32'h0000_2000: v = 8'hFF;
            default:       v = a[7:0] ^ (a[15:8] * 8'd3) ^ 8'h5A ^ a[31:24];
        endcase
        return v;
    endfunction

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        return ram_wr[a[15:0]] ? ram[a[15:0]] : init_byte(a);
    endfunction

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
    endfunction

    // Synchronous RAM: read data appears one cycle after its address.
    always @(posedge clk_in) begin
        bus.ram_din <= ram_rd(bus.ram_addr);
        if (bus.ram_we) begin
            ram[bus.ram_addr[15:0]]    <= bus.ram_dout;
            ram_wr[bus.ram_addr[15:0]] <= 1'b1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk_in);
        #1;
    endtask

    // One complete transaction started in an IDLE cycle (that cycle is cycle 0).
    task automatic run_txn(input bit is_mem, input bit we, input logic [31:0] addr,
                           input logic [1:0] len, input logic [31:0] wdata);
        int          n;
        int          lat;
        int          k;
        bit          seen;
        logic [31:0] exp_data;
        logic [31:0] ea;
        logic        exp_we;
        logic [7:0]  ed;

        n = !is_mem ? 4 : (len == 2'd0 ? 1 : (len == 2'd1 ? 2 : 4));
        lat = (is_mem && we) ? n + 1 : n + 2;
        exp_data = 32'd0;
        for (int i = 0; i < n; i++) exp_data[8*i +: 8] = ref_rd(addr + 32'(i));

        if (is_mem) begin
            bus.mem_req   = 1'b1;
            bus.mem_we    = we;
            bus.mem_addr  = addr;
            bus.mem_len   = len;
            bus.mem_wdata = wdata;
        end else begin
            bus.if_req  = 1'b1;
            bus.if_addr = addr;
        end

        k = 0;
        seen = 1'b0;
        while (!seen && k < 20) begin
            next_cycle();
            k++;
            ea = 32'd0;
            exp_we = 1'b0;
            ed = 8'd0;
            if (k <= n) begin
                ea = addr + 32'(k - 1);
                if (is_mem && we) begin
                    exp_we = 1'b1;
                    ed = wdata[8*(k-1) +: 8];
                end
            end
            check_eq("ram_addr", bus.ram_addr, ea);
            check_eq("ram_we", 32'(bus.ram_we), 32'(exp_we));
            check_eq("ram_dout", 32'(bus.ram_dout), 32'(ed));
            seen = is_mem ? bus.mem_done : bus.if_done;
            check_eq("other_done", 32'(is_mem ? bus.if_done : bus.mem_done), 32'd0);
            if (!seen) begin
                check_eq("if_data_hold", bus.if_data, exp_if_data);
                check_eq("mem_rdata_hold", bus.mem_rdata, exp_mem_rdata);
            end
        end

        bus.mem_req = 1'b0;
        bus.if_req  = 1'b0;
        check_eq("done_seen", 32'(seen), 32'd1);
        check_eq("latency", 32'(k), 32'(lat));

        if (is_mem && we) begin
            for (int i = 0; i < n; i++) ref_mem[addr + 32'(i)] = wdata[8*i +: 8];
        end else if (is_mem) begin
            exp_mem_rdata = exp_data;
        end else begin
            exp_if_data = exp_data;
        end
        check_eq("if_data", bus.if_data, exp_if_data);
        check_eq("mem_rdata", bus.mem_rdata, exp_mem_rdata);

        next_cycle();
        check_eq("if_done_pulse", 32'(bus.if_done), 32'd0);
        check_eq("mem_done_pulse", 32'(bus.mem_done), 32'd0);
        check_eq("idle_addr", bus.ram_addr, 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_addr"}, bus.ram_addr, 32'd0);
        check_eq({tag, "_we"}, 32'(bus.ram_we), 32'd0);
        check_eq({tag, "_dout"}, 32'(bus.ram_dout), 32'd0);
        check_eq({tag, "_if_done"}, 32'(bus.if_done), 32'd0);
        check_eq({tag, "_mem_done"}, 32'(bus.mem_done), 32'd0);
        check_eq({tag, "_if_data"}, bus.if_data, 32'd0);
        check_eq({tag, "_mem_rdata"}, bus.mem_rdata, 32'd0);
    endtask

    initial begin
        int          k;
        int          k_mem;
        int          k_if;
        logic [31:0] wd;

        bus.if_req    = 1'b0;
        bus.if_addr   = 32'd0;
        bus.flush_in  = 1'b0;
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = 32'd0;
        bus.mem_len   = 2'd0;
        bus.mem_wdata = 32'd0;
        exp_if_data   = 32'd0;
        exp_mem_rdata = 32'd0;

        #2;
        check_all_zero("reset");
        @(negedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b1;
        next_cycle();

        // Fetch of a known instruction.
        run_txn(1'b0, 1'b0, 32'h0000_0100, 2'd0, 32'd0);
        check_eq("fetch_insn", bus.if_data, 32'h00A0_0513);

        // Contention: MEM wins, then IF is granted from IDLE.
        bus.if_req   = 1'b1;
        bus.if_addr  = 32'h0000_0100;
        bus.mem_req  = 1'b1;
        bus.mem_we   = 1'b0;
        bus.mem_addr = 32'h0000_2000;
        bus.mem_len  = 2'd0;
        k = 0;
        k_mem = 0;
        k_if = 0;
        while (k_if == 0 && k < 30) begin
            next_cycle();
            k++;
            if (bus.mem_done) begin
                k_mem = k;
                bus.mem_req = 1'b0;
                check_eq("cont_rdata", bus.mem_rdata, 32'h0000_00FF);
            end
            if (bus.if_done) begin
                k_if = k;
                check_eq("cont_if_data", bus.if_data, 32'h00A0_0513);
            end
        end
        bus.if_req  = 1'b0;
        bus.mem_req = 1'b0;
        check_eq("cont_mem_cycle", 32'(k_mem), 32'd3);
        check_eq("cont_if_cycle", 32'(k_if), 32'd10);
        exp_mem_rdata = 32'h0000_00FF;
        next_cycle();

        // Halfword store, then read it back.
        run_txn(1'b1, 1'b1, 32'h0000_3000, 2'd1, 32'hDEAD_BEEF);
        run_txn(1'b1, 1'b0, 32'h0000_3000, 2'd1, 32'd0);
        check_eq("store_half_rb", bus.mem_rdata, 32'h0000_BEEF);

        // Flush in the third IF_RD cycle.
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_0100;
        next_cycle();
        next_cycle();
        next_cycle();
        bus.flush_in = 1'b1;
        next_cycle();
        bus.flush_in = 1'b0;
        bus.if_req   = 1'b0;
        check_eq("flush_idle_addr", bus.ram_addr, 32'd0);
        for (int i = 0; i < 8; i++) begin
            check_eq("flush_no_done", 32'(bus.if_done), 32'd0);
            check_eq("flush_if_data", bus.if_data, exp_if_data);
            next_cycle();
        end
        run_txn(1'b0, 1'b0, 32'h0000_0200, 2'd0, 32'd0);

        // Address wrap-around on a word load.
        run_txn(1'b1, 1'b0, 32'hFFFF_FFFE, 2'd2, 32'd0);

        // Randomized traffic in a small window.
        for (int t = 0; t < 40; t++) begin
            int          kind;
            logic [31:0] a;
            kind = $urandom_range(0, 2);
            a = 32'h0000_1000 + 32'($urandom_range(0, 63));
            if (kind == 0) run_txn(1'b0, 1'b0, a, 2'd0, 32'd0);
            else run_txn(1'b1, kind == 2, a, 2'($urandom_range(0, 3)), $urandom);
            repeat ($urandom_range(0, 2)) next_cycle();
        end

        // Reset asserted part-way through a word store.
        wd = $urandom;
        bus.mem_req   = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = 32'h0000_4000;
        bus.mem_len   = 2'd2;
        bus.mem_wdata = wd;
        next_cycle();
        next_cycle();
        check_eq("pre_rst_we", 32'(bus.ram_we), 32'd1);
        rst_in = 1'b0;
        #1;
        check_all_zero("midrst");
        bus.mem_req = 1'b0;
        next_cycle();
        check_all_zero("rst_hold");
        @(negedge clk_in);
        rst_in = 1'b1;
        exp_if_data   = 32'd0;
        exp_mem_rdata = 32'd0;
        for (int i = 0; i < 6; i++) begin
            next_cycle();
            check_eq("post_rst_no_done", 32'(bus.mem_done), 32'd0);
            check_eq("post_rst_addr", bus.ram_addr, 32'd0);
        end
        run_txn(1'b0, 1'b0, 32'h0000_0100, 2'd0, 32'd0);
        run_txn(1'b1, 1'b0, 32'h0000_3000, 2'd3, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
